// File: rtl/csr_pkg.sv
// Shared CSR addresses, mstatus/mip bit positions and the mcause layout used by the
// machine-mode CSR file.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam int MIP_MSIP = 3;
  localparam int MIP_MTIP = 7;
  localparam int MIP_MEIP = 11;

  localparam logic [31:0] MIE_MASK = (32'd1 << MIP_MEIP) | (32'd1 << MIP_MTIP) | (32'd1 << MIP_MSIP);

  typedef struct packed {
    logic        irq;
    logic [30:0] code;
  } cause_t;

  // Byte offset of a vectored interrupt entry: 4 * code, truncated to 32 bits.
  function automatic logic [31:0] vector_offset(cause_t c);
    return 32'({c.code, 2'b00});
  endfunction

endpackage

// File: rtl/csr_if.sv
// CSR file bus: EX read port, WB commit port, trap/mret controls, interrupt lines and
// the redirect outputs. master = pipeline side, slave = CSR file.
interface csr_if;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        csr_wreq;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        instr_retire;
  logic        trap_valid;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_val;
  logic        mret_valid;
  logic        irq_ext;
  logic        irq_timer;
  logic        irq_sw;
  logic [31:0] trap_target;
  logic [31:0] epc;
  logic        irq_pending;

  modport master (
    output csr_raddr, csr_wreq, csr_we, csr_waddr, csr_wdata, instr_retire,
           trap_valid, trap_cause, trap_pc, trap_val, mret_valid,
           irq_ext, irq_timer, irq_sw,
    input  csr_rdata, csr_illegal, trap_target, epc, irq_pending
  );

  modport slave (
    input  csr_raddr, csr_wreq, csr_we, csr_waddr, csr_wdata, instr_retire,
           trap_valid, trap_cause, trap_pc, trap_val, mret_valid,
           irq_ext, irq_timer, irq_sw,
    output csr_rdata, csr_illegal, trap_target, epc, irq_pending
  );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently writable halves; a write in a cycle
// replaces that half and suppresses the increment. Wraps from all-ones to zero.
module csr_counter64 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) count[31:0]  <= wdata;
      if (wr_hi) count[63:32] <= wdata;
    end else if (inc) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/csr_file.sv
// Machine-mode Zicsr register file: zero-latency combinational read for EX, commit on
// the clock edge in WB, trap/mret state and the cycle/instret counters. No backpressure.
module csr_file
  import csr_pkg::*;
#(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input logic  clk,
  input logic  reset_n,
  csr_if.slave bus
);

  logic        mst_mie;
  logic        mst_mpie;
  logic [31:0] mie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;
  logic [31:0] mip;
  logic [63:0] mcycle;
  logic [63:0] minstret;
  logic [31:0] rdata;
  logic        unimpl;
  logic [31:0] tvec_base;
  cause_t      cause;

  always_comb begin
    mip           = '0;
    mip[MIP_MEIP] = bus.irq_ext;
    mip[MIP_MTIP] = bus.irq_timer;
    mip[MIP_MSIP] = bus.irq_sw;
  end

  // Trap beats mret beats a WB write for the trap-state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mst_mie  <= 1'b0;
      mst_mpie <= 1'b0;
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else if (bus.trap_valid) begin
      mepc_q   <= bus.trap_pc & ~32'h3;
      mcause_q <= bus.trap_cause;
      mtval_q  <= bus.trap_val;
      mst_mpie <= mst_mie;
      mst_mie  <= 1'b0;
    end else if (bus.mret_valid) begin
      mst_mie  <= mst_mpie;
      mst_mpie <= 1'b1;
    end else if (bus.csr_we) begin
      case (bus.csr_waddr)
        CSR_MSTATUS: begin
          mst_mie  <= bus.csr_wdata[MSTATUS_MIE];
          mst_mpie <= bus.csr_wdata[MSTATUS_MPIE];
        end
        CSR_MEPC:   mepc_q   <= bus.csr_wdata & ~32'h3;
        CSR_MCAUSE: mcause_q <= bus.csr_wdata;
        CSR_MTVAL:  mtval_q  <= bus.csr_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
    end else if (bus.csr_we) begin
      case (bus.csr_waddr)
        CSR_MIE:      mie_q      <= bus.csr_wdata & MIE_MASK;
        // Reserved modes 2 and 3 collapse to direct mode.
        CSR_MTVEC:    mtvec_q    <= {bus.csr_wdata[31:2], bus.csr_wdata[1] ? 2'b00 : bus.csr_wdata[1:0]};
        CSR_MSCRATCH: mscratch_q <= bus.csr_wdata;
        default: ;
      endcase
    end
  end

  csr_counter64 u_mcycle (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (1'b1),
    .wr_lo   (bus.csr_we && bus.csr_waddr == CSR_MCYCLE),
    .wr_hi   (bus.csr_we && bus.csr_waddr == CSR_MCYCLEH),
    .wdata   (bus.csr_wdata),
    .count   (mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (bus.instr_retire),
    .wr_lo   (bus.csr_we && bus.csr_waddr == CSR_MINSTRET),
    .wr_hi   (bus.csr_we && bus.csr_waddr == CSR_MINSTRETH),
    .wdata   (bus.csr_wdata),
    .count   (minstret)
  );

  always_comb begin
    rdata  = '0;
    unimpl = 1'b0;
    case (bus.csr_raddr)
      CSR_MSTATUS: begin
        rdata[MSTATUS_MIE]                   = mst_mie;
        rdata[MSTATUS_MPIE]                  = mst_mpie;
        rdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
      CSR_MISA:                    rdata = MISA_VAL;
      CSR_MIE:                     rdata = mie_q;
      CSR_MTVEC:                   rdata = mtvec_q;
      CSR_MSCRATCH:                rdata = mscratch_q;
      CSR_MEPC:                    rdata = mepc_q;
      CSR_MCAUSE:                  rdata = mcause_q;
      CSR_MTVAL:                   rdata = mtval_q;
      CSR_MIP:                     rdata = mip;
      CSR_MCYCLE,   CSR_CYCLE:     rdata = mcycle[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:    rdata = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:   rdata = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: rdata = minstret[63:32];
      CSR_MHARTID:                 rdata = HART_ID;
      default:                     unimpl = 1'b1;
    endcase
  end

  assign bus.csr_rdata   = rdata;
  assign bus.csr_illegal = unimpl | (bus.csr_wreq & (bus.csr_raddr[11:10] == 2'b11));

  assign cause           = cause_t'(bus.trap_cause);
  assign tvec_base       = {mtvec_q[31:2], 2'b00};
  assign bus.trap_target = (mtvec_q[1:0] == 2'b01 && cause.irq) ? tvec_base + vector_offset(cause)
                                                                : tvec_base;
  assign bus.epc         = mepc_q;
  assign bus.irq_pending = mst_mie & (|(mie_q & mip));

endmodule
